regularization: RTL and testbench
=================================

Name: regularization

Overview:
- Per-bit debounce-plus-lockout filter for N independent binary condition signals. Examples are sign bits of switching-surface evaluations in the hybrid resonant-converter controller.
- Each output bit follows its input only after the input has disagreed with it for DEBOUNCE_TIME consecutive cycles.
- After each output change, that bit ignores its input for DELAY cycles. This regularizes jumps and suppresses chattering near the switching surface.
- Sits between the surface-sign computation and the jump-detection logic.

Parameters:
- DEBOUNCE_TIME, 2, consecutive disagreeing samples required before an output bit changes; legal range ≥1.
- DELAY, 100, lockout length in clock cycles after an output bit changes; legal range ≥0.
- N, 2, number of independent signal bits; legal range ≥1.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_signal  input  N  raw condition bits; assumed synchronous to i_clk, no internal synchronizer.
- o_signal  output  N  filtered condition bits; registered.

Behaviour:
- Each bit i has its own registers:
  - out[i], drives o_signal[i].
  - deb_cnt[i], width clog2(DEBOUNCE_TIME+1).
  - hold_cnt[i], width clog2(DELAY+1), min 1 bit.
- Bits never interact. Lockout on one bit does not affect the others.
- Reset: when i_reset=1 at a rising edge, all out, deb_cnt and hold_cnt clear to 0. o_signal=0 from the next cycle. Reset takes priority over every other action, including mid-debounce and mid-lockout.
- Per-bit update each rising edge, with i_reset=0:
  - Lockout: if hold_cnt[i]≠0, decrement hold_cnt[i], force deb_cnt[i]=0, hold out[i]. i_signal[i] is ignored.
  - Else, if i_signal[i]==out[i]: deb_cnt[i]=0, out[i] held.
  - Else, if deb_cnt[i]+1 < DEBOUNCE_TIME: increment deb_cnt[i], out[i] held.
  - Else (DEBOUNCE_TIME-th consecutive disagreeing sample): out[i]=i_signal[i], deb_cnt[i]=0, hold_cnt[i]=DELAY.
- Latency: an input step that stays stable changes o_signal[i] on the DEBOUNCE_TIME-th rising edge that samples the new value. With DEBOUNCE_TIME=1 this is one registered cycle of delay.
- Glitch rejection: any disagreement shorter than DEBOUNCE_TIME consecutive samples leaves o_signal unchanged and resets the count.
- Lockout:
  - After an output change at edge E, the edges E+1..E+DELAY ignore the input.
  - Evaluation resumes at edge E+DELAY+1.
  - Minimum spacing between two changes of one bit is DELAY+DEBOUNCE_TIME edges.
  - DELAY=0 means no lockout.
- Input differing at the end of lockout: counting starts at the first non-lockout edge. Samples taken during lockout never count toward debounce.
- o_signal is a pure register output, with no combinational path from i_signal.
- Synthesizable; no initial blocks relied on for function.

Test Plan:
- Reset: drive i_reset=1 for 3 cycles with i_signal=2'b11 → o_signal=2'b00 throughout and on the first cycle after release; stale counts are not used.
- Step response (defaults): after reset, set i_signal=2'b01 and hold → o_signal[0] rises exactly on the 2nd edge sampling 1, and o_signal[1] stays 0.
- Glitch rejection: with o_signal=2'b00 and not in lockout, pulse i_signal[0]=1 for 1 cycle → o_signal stays 2'b00. A later 2-cycle pulse → o_signal[0]=1.
- Lockout: o_signal[0] just went 0→1 at edge E; drop i_signal[0] to 0 at edge E+1 and hold → o_signal[0] stays 1 through edge E+100 and falls at edge E+102 (DEBOUNCE_TIME=2 after lockout ends at E+100).
- Independence: toggle bit 1 while bit 0 is locked out → bit 1 updates after 2 stable samples, unaffected by bit 0's hold counter.
- Parameter corners:
  - Instantiate DEBOUNCE_TIME=1, DELAY=0, N=4; apply random i_signal → o_signal equals i_signal delayed one cycle.
  - Instantiate DEBOUNCE_TIME=5, DELAY=3; a 4-cycle pulse is rejected and a 5-cycle pulse is passed.

Source files
------------

// File: rtl/regularization.sv
// Per-bit debounce-plus-lockout filter: each output bit follows its input only after
// DEBOUNCE_TIME consecutive disagreeing samples, then ignores the input for DELAY cycles.
module regularization #(
  parameter int unsigned DEBOUNCE_TIME = 2,
  parameter int unsigned DELAY         = 100,
  parameter int unsigned N             = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_signal,
  output logic [N-1:0] o_signal
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TIME + 1);
  localparam int unsigned HOLD_W = (DELAY == 0) ? 1 : $clog2(DELAY + 1);

  logic [N-1:0]      out_q, out_d;
  logic [DEB_W-1:0]  deb_q  [N];
  logic [DEB_W-1:0]  deb_d  [N];
  logic [HOLD_W-1:0] hold_q [N];
  logic [HOLD_W-1:0] hold_d [N];

  // Next-state logic; bits are fully independent of each other
  always_comb begin
    out_d  = out_q;
    deb_d  = deb_q;
    hold_d = hold_q;
    for (int i = 0; i < int'(N); i++) begin
      if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - HOLD_W'(1);
        deb_d[i]  = '0;
      end else if (i_signal[i] == out_q[i]) begin
        deb_d[i] = '0;
      end else if ((32'(deb_q[i]) + 32'd1) < 32'(DEBOUNCE_TIME)) begin
        deb_d[i] = deb_q[i] + DEB_W'(1);
      end else begin
        out_d[i]  = i_signal[i];
        deb_d[i]  = '0;
        hold_d[i] = HOLD_W'(DELAY);
      end
    end
  end

  // State registers; reset overrides debounce and lockout in progress
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q  <= '0;
      deb_q  <= '{default: '0};
      hold_q <= '{default: '0};
    end else begin
      out_q  <= out_d;
      deb_q  <= deb_d;
      hold_q <= hold_d;
    end
  end

  assign o_signal = out_q;

endmodule

// File: tb/tb_regularization.sv
// Directed self-checking bench for regularization: default instance plus two
// parameter-corner instances sharing clock and reset.
module tb_regularization;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sig, out;
  logic [3:0] sig_a, out_a;
  logic [0:0] sig_b, out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regularization dut (
    .i_clk(clk), .i_reset(rst), .i_signal(sig), .o_signal(out)
  );

  regularization #(.DEBOUNCE_TIME(1), .DELAY(0), .N(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_signal(sig_a), .o_signal(out_a)
  );

  regularization #(.DEBOUNCE_TIME(5), .DELAY(3), .N(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_signal(sig_b), .o_signal(out_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sig = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected 00", k, out);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got %b expected 00", out);
    end
    // one disagreeing sample is now counted; reset must discard it
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_debounce: got %b expected 00", out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL reset_stale_count: got %b expected 00", out);
    end
    sig = 2'b00;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL reset_settle: got %b expected 00", out);
    end
  endtask

  // Ends exactly at edge E, where out[0] has just risen
  task automatic test_step();
    sig = 2'b01;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL step_edge1: got %b expected 00", out);
    end
    tick();
    checks++;
    if (out !== 2'b01) begin
      errors++;
      $display("FAIL step_edge2: got %b expected 01", out);
    end
  endtask

  // Bit 0 locked from E+1..E+100; bit 1 toggles from E+10 and must rise at E+11
  task automatic test_lockout_independence();
    logic [1:0] exp;
    for (int k = 1; k <= 102; k++) begin
      sig = {(k >= 10) ? 1'b1 : 1'b0, 1'b0};
      tick();
      exp = {(k >= 11) ? 1'b1 : 1'b0, (k <= 101) ? 1'b1 : 1'b0};
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL lockout_E+%0d: got %b expected %b", k, out, exp);
      end
    end
  endtask

  // Reset during lockout, then glitch rejection on a clean filter
  task automatic test_glitch();
    rst = 1'b1;
    sig = 2'b00;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_lockout: got %b expected 00", out);
    end
    rst = 1'b0;
    sig = 2'b01;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL glitch_1cyc_a: got %b expected 00", out);
    end
    sig = 2'b00;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out !== 2'b00) begin
        errors++;
        $display("FAIL glitch_1cyc_after[%0d]: got %b expected 00", k, out);
      end
    end
    sig = 2'b01;
    tick();
    checks++;
    if (out !== 2'b00) begin
      errors++;
      $display("FAIL glitch_2cyc_a: got %b expected 00", out);
    end
    tick();
    checks++;
    if (out !== 2'b01) begin
      errors++;
      $display("FAIL glitch_2cyc_b: got %b expected 01", out);
    end
  endtask

  // DEBOUNCE_TIME=1, DELAY=0: output is input delayed by one edge
  task automatic test_corner_passthrough();
    logic [3:0] v;
    for (int k = 0; k < 20; k++) begin
      v = 4'($urandom);
      sig_a = v;
      tick();
      checks++;
      if (out_a !== v) begin
        errors++;
        $display("FAIL passthrough[%0d]: got %b expected %b", k, out_a, v);
      end
    end
  endtask

  // DEBOUNCE_TIME=5, DELAY=3: 4-cycle pulse rejected, 5-cycle passed, then lockout+debounce
  task automatic test_corner_long_debounce();
    logic exp;
    sig_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_b !== 1'b0) begin
        errors++;
        $display("FAIL pulse4[%0d]: got %b expected 0", k, out_b);
      end
    end
    sig_b = 1'b0;
    tick();
    checks++;
    if (out_b !== 1'b0) begin
      errors++;
      $display("FAIL pulse4_after: got %b expected 0", out_b);
    end
    sig_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == 5);
      checks++;
      if (out_b !== exp) begin
        errors++;
        $display("FAIL pulse5[%0d]: got %b expected %b", k, out_b, exp);
      end
    end
    // lockout E+1..E+3, counting E+4..E+8, fall at E+8
    sig_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k < 8);
      checks++;
      if (out_b !== exp) begin
        errors++;
        $display("FAIL corner_lockout_E+%0d: got %b expected %b", k, out_b, exp);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    sig   = 2'b00;
    sig_a = 4'h0;
    sig_b = 1'b0;
    test_reset();
    test_step();
    test_lockout_independence();
    test_glitch();
    test_corner_passthrough();
    test_corner_long_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
